// File: rtl/sms_trigger_pkg.sv
// Shared types and helpers for the SDTRL trigger card: per-channel action encoding
// and the pulse-filter counter width.
package sms_trigger_pkg;

  typedef enum logic [1:0] {
    TRG_HOLD  = 2'd0,
    TRG_SET   = 2'd1,
    TRG_RESET = 2'd2,
    TRG_CPL   = 2'd3
  } trg_action_t;

  // Counter must be able to hold the value FILTER_CYCLES itself (saturation point).
  function automatic int filter_cnt_w(input int filter_cycles);
    return $clog2(filter_cycles + 1);
  endfunction

endpackage

// File: rtl/sms_pulse_filter.sv
// Deglitcher for one active-low pulse input: accepts a low pulse after FILTER_CYCLES
// consecutive low samples and emits a one-cycle strobe on the accepting edge.
module sms_pulse_filter
  import sms_trigger_pkg::*;
#(
  parameter int FILTER_CYCLES = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic din,
  output logic level,
  output logic fall_ev
);

  localparam int CW = filter_cnt_w(FILTER_CYCLES);
  localparam logic [CW-1:0] CNT_MAX  = CW'(FILTER_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(FILTER_CYCLES - 1);

  logic [CW-1:0] cnt;

  // The strobe is combinational so the trigger updates on the very edge whose
  // sample completes the low run, rather than one cycle later.
  assign fall_ev = ~din & level & (cnt == CNT_LAST);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt   <= '0;
      level <= 1'b1;
    end else if (din) begin
      cnt   <= '0;
      level <= 1'b1;
    end else begin
      if (cnt != CNT_MAX) cnt <= cnt + 1'b1;
      if (fall_ev) level <= 1'b0;
    end
  end

endmodule

// File: rtl/sms_trigger_card_n.sv
// N-channel SDTRL trigger card: filtered AC set/reset/toggle pulses with gate setup,
// DC overrides, and an open-collector wired-AND dot output.
module sms_trigger_card_n
  import sms_trigger_pkg::*;
#(
  parameter int CHANNELS      = 4,
  parameter int FILTER_CYCLES = 2
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [CHANNELS-1:0]     set_gate,
  input  logic [CHANNELS-1:0]     set_pulse,
  input  logic [CHANNELS-1:0]     rst_gate,
  input  logic [CHANNELS-1:0]     rst_pulse,
  input  logic [CHANNELS-1:0]     tgl_pulse,
  input  logic [CHANNELS-1:0]     dc_set_n,
  input  logic [CHANNELS-1:0]     dc_rst_n,
  input  logic [CHANNELS-1:0]     oc_en,
  output logic [CHANNELS-1:0]     q,
  output logic [CHANNELS-1:0]     q_n,
  output logic                    dot_out,
  output logic [3*CHANNELS-1:0]   filt_level_dbg
);

  logic [CHANNELS-1:0] set_fev, rst_fev, tgl_ev;
  logic [CHANNELS-1:0] set_lvl, rst_lvl, tgl_lvl;
  logic [CHANNELS-1:0] set_gate_q, rst_gate_q;
  logic [CHANNELS-1:0] set_ev, rst_ev;
  logic [CHANNELS-1:0] q_next;
  trg_action_t         act [CHANNELS];

  for (genvar i = 0; i < CHANNELS; i++) begin : g_filt
    sms_pulse_filter #(.FILTER_CYCLES(FILTER_CYCLES)) u_set (
      .clk(clk), .reset_n(reset_n), .din(set_pulse[i]), .level(set_lvl[i]), .fall_ev(set_fev[i]));
    sms_pulse_filter #(.FILTER_CYCLES(FILTER_CYCLES)) u_rst (
      .clk(clk), .reset_n(reset_n), .din(rst_pulse[i]), .level(rst_lvl[i]), .fall_ev(rst_fev[i]));
    sms_pulse_filter #(.FILTER_CYCLES(FILTER_CYCLES)) u_tgl (
      .clk(clk), .reset_n(reset_n), .din(tgl_pulse[i]), .level(tgl_lvl[i]), .fall_ev(tgl_ev[i]));
  end

  assign filt_level_dbg = {tgl_lvl, rst_lvl, set_lvl};

  // Gates are registered so they must be stable one edge before the pulse is accepted.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      set_gate_q <= '0;
      rst_gate_q <= '0;
    end else begin
      set_gate_q <= set_gate;
      rst_gate_q <= rst_gate;
    end
  end

  assign set_ev = set_fev & set_gate_q;
  assign rst_ev = rst_fev & rst_gate_q;

  always_comb begin
    for (int i = 0; i < CHANNELS; i++) begin
      act[i] = TRG_HOLD;
      if (!dc_rst_n[i])                      act[i] = TRG_RESET;
      else if (!dc_set_n[i])                 act[i] = TRG_SET;
      else if (tgl_ev[i] || (set_ev[i] && rst_ev[i])) act[i] = TRG_CPL;
      else if (set_ev[i])                    act[i] = TRG_SET;
      else if (rst_ev[i])                    act[i] = TRG_RESET;
    end
  end

  always_comb begin
    q_next = q;
    for (int i = 0; i < CHANNELS; i++) begin
      case (act[i])
        TRG_SET:   q_next[i] = 1'b1;
        TRG_RESET: q_next[i] = 1'b0;
        TRG_CPL:   q_next[i] = ~q[i];
        default:   q_next[i] = q[i];
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) q <= '0;
    else          q <= q_next;
  end

  assign q_n     = ~q;
  // Disabled channels float high on the dot line.
  assign dot_out = &(q_n | ~oc_en);

endmodule
